fill_master: RTL and testbench

FILL_MASTER -- requirements
Module: fill_master

---
 rtl/fill_master.sv | 132 +++++++++++++
 tb/tb_fill_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fill_master.sv
// fill_master: Avalon-MM write master that fills a block of memory.
//
// A fill is started from idle by 'start'. The block then issues 'word_count'
// back-to-back word writes beginning at 'base_addr', advancing the address by
// WORD_BYTES per accepted transfer. Data is either constant ('fill_value') or
// increments by one per word when 'incr' is set. A single-cycle 'done' pulse
// marks completion. All outputs come straight from registers.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request a fill (sampled only while idle)
//   base_addr    byte address of the first word (sampled with start)
//   word_count   number of words to write (sampled with start)
//   fill_value   first data word (sampled with start)
//   incr         1: data increments per word, 0: constant data
//   busy         high while writing and during the done cycle
//   done         one-cycle completion pulse
//   address      Avalon-MM byte address
//   writedata    Avalon-MM write data
//   write        Avalon-MM write request
//   waitrequest  Avalon-MM slave stall

module fill_master #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [31:0]            fill_value,
    input  logic                   incr,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            address,
    output logic [31:0]            writedata,
    output logic                   write,
    input  logic                   waitrequest
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

    state_e                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_write;
    logic [31:0]            r_address;
    logic [31:0]            r_writedata;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_incr;

    logic [31:0]            w_addr_step;
    logic [31:0]            w_data_step;
    logic                   w_last;

    assign w_addr_step = 32'(WORD_BYTES);
    assign w_data_step = {31'b0, r_incr};
    assign w_last      = (r_remaining == COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'h0;
            r_writedata <= 32'h0;
            r_remaining <= '0;
            r_incr      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        // Parameters are captured into the output registers so
                        // later input changes cannot disturb the fill.
                        r_address   <= base_addr;
                        r_writedata <= fill_value;
                        r_remaining <= word_count;
                        r_incr      <= incr;
                        r_busy      <= 1'b1;
                        if (word_count != '0) begin
                            r_state <= StWrite;
                            r_write <= 1'b1;
                        end else begin
                            // Empty fill: skip straight to completion.
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (!waitrequest) begin
                        if (w_last) begin
                            r_state     <= StDone;
                            r_write     <= 1'b0;
                            r_done      <= 1'b1;
                            r_remaining <= '0;
                        end else begin
                            r_address   <= r_address + w_addr_step;
                            r_writedata <= r_writedata + w_data_step;
                            r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_write <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign write     = r_write;
    assign address   = r_address;
    assign writedata = r_writedata;

endmodule

// File: tb/tb_fill_master.sv
// Testbench for fill_master: directed and randomized fills checked against a
// reference model that derives each transfer from the fill parameters
// (address = base + i*WORD_BYTES, data = value + i when incrementing).

module tb_fill_master;

    localparam int unsigned WB = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [31:0]   base_addr;
    logic [CW-1:0] word_count;
    logic [31:0]   fill_value;
    logic          incr;
    logic          busy;
    logic          done;
    logic [31:0]   address;
    logic [31:0]   writedata;
    logic          write;
    logic          waitrequest;

    int n_checks = 0;
    int n_pass   = 0;

    fill_master #(
        .WORD_BYTES (WB),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .fill_value (fill_value),
        .incr       (incr),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .writedata  (writedata),
        .write      (write),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Stall cycles inserted before a transfer is accepted.
    function automatic int pick_stall(input int mode);
        if (mode == 0) return 0;
        if (mode == 2) return 2;
        return int'($urandom_range(0, 2));
    endfunction

    // One complete fill, driven and checked from negedge to negedge.
    task automatic run_fill(input logic [31:0] base, input int cnt, input logic [31:0] val,
                            input logic inc, input int mode);
        int          cyc;
        int          accepted;
        int          stalls;
        int          stall_left;
        logic        prev_stall;
        logic [31:0] held_a;
        logic [31:0] held_d;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        cyc        = 0;
        accepted   = 0;
        stalls     = 0;
        prev_stall = 1'b0;
        held_a     = '0;
        held_d     = '0;
        @(negedge clk);
        base_addr   = base;
        word_count  = cnt[CW-1:0];
        fill_value  = val;
        incr        = inc;
        start       = 1'b1;
        waitrequest = 1'b0;
        @(negedge clk);
        cyc        = 1;
        start      = 1'b0;
        stall_left = pick_stall(mode);
        while (done !== 1'b1 && cyc < 300) begin
            if (prev_stall) begin
                check("stall_hold_addr", address, held_a);
                check("stall_hold_data", writedata, held_d);
                check("stall_hold_write", {31'b0, write}, 32'd1);
            end
            check("busy_during_fill", {31'b0, busy}, 32'd1);
            prev_stall = 1'b0;
            if (write === 1'b1) begin
                if (stall_left > 0) begin
                    waitrequest = 1'b1;
                    prev_stall  = 1'b1;
                    held_a      = address;
                    held_d      = writedata;
                    stall_left--;
                    stalls++;
                end else begin
                    waitrequest = 1'b0;
                    exp_a = base + 32'(accepted) * WB;
                    exp_d = inc ? val + 32'(accepted) : val;
                    check("xfer_addr", address, exp_a);
                    check("xfer_data", writedata, exp_d);
                    accepted++;
                    stall_left = pick_stall(mode);
                end
            end else begin
                waitrequest = 1'b0;
            end
            // Inputs wiggling while busy must not disturb the fill.
            start      = 1'($urandom_range(0, 1));
            base_addr  = $urandom;
            word_count = CW'($urandom);
            fill_value = $urandom;
            incr       = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start       = 1'b0;
        waitrequest = 1'b0;
        check("done_seen", {31'b0, done}, 32'd1);
        check("xfer_count", 32'(accepted), 32'(cnt));
        // Start sampled at one edge, first write the next cycle, done one cycle
        // after the last accepted write.
        check("start_to_done", 32'(cyc), 32'(cnt + stalls + 1));
        check("done_write_low", {31'b0, write}, 32'd0);
        check("done_busy_high", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("done_single_cycle", {31'b0, done}, 32'd0);
        check("idle_busy_low", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          accepted;
        logic [31:0] rb;
        reset_n     = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        word_count  = '0;
        fill_value  = '0;
        incr        = 1'b0;
        waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_write", {31'b0, write}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_addr", address, 32'h0);
        check("rst_data", writedata, 32'h0);
        reset_n = 1'b1;

        // Constant data, no stalls.
        run_fill(32'h0000_1000, 4, 32'hA5A5_A5A5, 1'b0, 0);
        // Incrementing data, two stall cycles per transfer.
        run_fill(32'h0000_0000, 3, 32'h0000_0010, 1'b1, 2);
        // Empty fill.
        run_fill(32'h0000_2000, 0, 32'h1234_5678, 1'b1, 0);
        // Address wrap through 2^32.
        run_fill(32'hFFFF_FFF8, 3, 32'h5A5A_5A5A, 1'b0, 0);
        // Data wrap through 2^32.
        run_fill(32'h0000_0040, 3, 32'hFFFF_FFFE, 1'b1, 1);

        // Randomized fills with random stalls.
        for (int i = 0; i < 8; i++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            run_fill(rb, int'($urandom_range(1, 6)), $urandom, 1'($urandom_range(0, 1)), 1);
        end

        // Reset mid-fill after the third accepted transfer.
        @(negedge clk);
        base_addr  = 32'h0000_3000;
        word_count = CW'(8);
        fill_value = 32'hDEAD_0000;
        incr       = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        accepted = 0;
        for (int c = 0; c < 20 && accepted < 3; c++) begin
            if (write === 1'b1) accepted++;
            @(negedge clk);
        end
        check("pre_reset_write", {31'b0, write}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_write", {31'b0, write}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_addr", address, 32'h0);
        check("async_rst_data", writedata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("post_abort_idle", {31'b0, busy}, 32'd0);
        run_fill(32'h0000_4000, 2, 32'h0000_0100, 1'b0, 0);

        // Start held high with single-word fills: write, done, idle, repeat.
        @(negedge clk);
        base_addr  = 32'h0000_5000;
        word_count = CW'(1);
        fill_value = 32'h7777_7777;
        incr       = 1'b0;
        start      = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("held_start_write", {31'b0, write}, (k % 3 == 1) ? 32'd1 : 32'd0);
            check("held_start_done", {31'b0, done}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 1) check("held_start_addr", address, 32'h0000_5000);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
